// File: rtl/run_sequencer.sv
// Host-side job sequencer: buffers run commands, launches them one at a time on
// all node controllers, waits for completion and optionally rotates base ids.
module run_sequencer #(
  parameter int node_num      = 8,
  parameter int fifo_depth    = 4,
  parameter int start_timeout = 8
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic [23:0]         cmd_times,
  input  logic                cmd_rotate,
  input  logic                abort,
  input  logic                err_clear,
  output logic                run_write,
  output logic [23:0]         run_times,
  input  logic [node_num-1:0] node_running,
  output logic                change_base_id,
  output logic                busy,
  output logic                job_done,
  output logic [15:0]         done_count,
  output logic                err_zero,
  output logic                err_start
);

  localparam int AW = $clog2(fifo_depth);
  localparam int TW = $clog2(start_timeout + 1);

  typedef enum logic [2:0] {IDLE, LAUNCH, WAIT_START, WAIT_DONE, ROTATE, SETTLE} state_t;

  state_t              state, next_state;
  logic [24:0]         mem [fifo_depth];
  logic [AW:0]         wr_ptr, rd_ptr;
  logic                full, empty, accept, zero_cmd, push, pop;
  logic                start_fail;
  logic                rot_q;
  logic [node_num-1:0] run_q;
  logic [TW-1:0]       to_cnt;

  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign cmd_ready = !full;
  assign accept    = cmd_valid && !full;
  assign zero_cmd  = accept && (cmd_times == '0);
  assign push      = accept && !zero_cmd && !abort;
  assign pop       = (state == IDLE) && !empty && !abort;
  assign busy      = (state != IDLE) || !empty;

  always_comb begin
    next_state = state;
    start_fail = 1'b0;
    case (state)
      IDLE:       if (pop) next_state = LAUNCH;
      LAUNCH:     next_state = WAIT_START;
      WAIT_START: begin
        if (&run_q) begin
          next_state = WAIT_DONE;
        end else if (to_cnt == TW'(start_timeout - 1)) begin
          start_fail = 1'b1;
          next_state = IDLE;
        end
      end
      WAIT_DONE:  if (run_q == '0) next_state = rot_q ? ROTATE : IDLE;
      ROTATE:     next_state = SETTLE;
      SETTLE:     next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {cmd_times, cmd_rotate};
  end

  always_ff @(posedge clk) begin
    run_q <= node_running;
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      to_cnt         <= '0;
      rot_q          <= 1'b0;
      run_write      <= 1'b0;
      run_times      <= '0;
      change_base_id <= 1'b0;
      job_done       <= 1'b0;
      done_count     <= '0;
      err_zero       <= 1'b0;
      err_start      <= 1'b0;
    end else begin
      state <= next_state;
      if (abort) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
        if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      end
      if (pop) {run_times, rot_q} <= mem[rd_ptr[AW-1:0]];
      // Pulses are registered from the next-state decode so each one lines up
      // with the cycle the FSM spends in the corresponding state.
      run_write      <= (next_state == LAUNCH);
      change_base_id <= (next_state == ROTATE);
      job_done       <= (next_state == WAIT_DONE) && (node_running == '0);
      if (state == WAIT_DONE && run_q == '0) done_count <= done_count + 16'd1;
      if (state == LAUNCH)          to_cnt <= '0;
      else if (state == WAIT_START) to_cnt <= to_cnt + TW'(1);
      if (zero_cmd)       err_zero  <= 1'b1;
      else if (err_clear) err_zero  <= 1'b0;
      if (start_fail)     err_start <= 1'b1;
      else if (err_clear) err_start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_run_sequencer.sv
// Bench for run_sequencer: timeline-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_run_sequencer;
  localparam int NN = 8, DEPTH = 4, T = 8;
  localparam int BIG = 32'h7fffffff;

  logic          clk = 1'b0;
  logic          reset = 1'b1, cmd_valid = 1'b0, cmd_rotate = 1'b0, abort = 1'b0, err_clear = 1'b0;
  logic [23:0]   cmd_times = '0;
  logic [NN-1:0] node_running;
  logic          cmd_ready, run_write, change_base_id, busy, job_done, err_zero, err_start;
  logic [23:0]   run_times;
  logic [15:0]   done_count;

  run_sequencer #(.node_num(NN), .fifo_depth(DEPTH), .start_timeout(T)) dut (
    .clk(clk), .reset(reset), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_times(cmd_times), .cmd_rotate(cmd_rotate), .abort(abort), .err_clear(err_clear),
    .run_write(run_write), .run_times(run_times), .node_running(node_running),
    .change_base_id(change_base_id), .busy(busy), .job_done(job_done),
    .done_count(done_count), .err_zero(err_zero), .err_start(err_start));

  always #5 clk = ~clk;

  int tests = 0, fails = 0;
  int cyc = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: a command queue plus a timeline of the current job
  // (launch cycle, start-detect cycle, done cycle, cycle it becomes free).
  logic [24:0] q[$];
  logic [24:0] head;
  bit          mvalid = 0, active = 0, job_rot = 0, acc;
  int          t_free = 0, t_launch = -10, t_start = -1, t_done = -10, t_err = -10, sz;
  logic        e_rw = 0, e_cbi = 0, e_jd = 0, e_ez = 0, e_es = 0;
  logic [23:0] e_rt = '0;
  logic [15:0] e_dc = '0;

  always @(posedge clk) begin
    cyc++;
    if (reset) begin
      q.delete();
      mvalid = 1; active = 0; job_rot = 0;
      t_free = cyc; t_launch = -10; t_start = -1; t_done = -10; t_err = -10;
      e_rt = '0; e_dc = '0; e_ez = 0; e_es = 0;
    end else begin
      sz  = q.size();
      acc = cmd_valid && (sz < DEPTH);
      if (cyc - 1 >= t_free && sz > 0 && !abort) begin
        head = q.pop_front();
        e_rt = head[24:1]; job_rot = head[0];
        t_launch = cyc; t_start = -1; t_free = BIG; active = 1;
      end
      if (abort) q.delete();
      else if (acc && cmd_times != 0) q.push_back({cmd_times, cmd_rotate});
      if (acc && cmd_times == 0) e_ez = 1;
      else if (err_clear)        e_ez = 0;
      if (cyc == t_err)   e_es = 1;
      else if (err_clear) e_es = 0;
      if (cyc == t_done + 1) e_dc = e_dc + 16'd1;
      if (active && cyc > t_launch) begin
        if (t_start < 0) begin
          if (&node_running) t_start = cyc + 1;
          else if (cyc == t_launch + T) begin
            t_err = cyc + 1; t_free = cyc + 1; active = 0;
          end
        end else if (cyc >= t_start && node_running == '0) begin
          t_done = cyc; t_free = job_rot ? cyc + 3 : cyc + 1; active = 0;
        end
      end
    end
    e_rw  = (cyc == t_launch);
    e_jd  = (cyc == t_done);
    e_cbi = job_rot && (cyc == t_done + 1);
  end

  always @(negedge clk) begin
    if (mvalid) begin
      chk("run_write", run_write, e_rw);
      chk("run_times", run_times, e_rt);
      chk("change_base_id", change_base_id, e_cbi);
      chk("job_done", job_done, e_jd);
      chk("done_count", done_count, e_dc);
      chk("err_zero", err_zero, e_ez);
      chk("err_start", err_start, e_es);
      chk("busy", busy, (cyc < t_free) || (q.size() > 0));
      chk("cmd_ready", cmd_ready, q.size() < DEPTH);
    end
  end

  // Event logs used by the directed literal checks.
  int rw_cyc[$], rw_val[$], jd_cyc[$], cbi_cyc[$];
  always @(negedge clk) begin
    if (run_write === 1'b1)      begin rw_cyc.push_back(cyc); rw_val.push_back(int'(run_times)); end
    if (job_done === 1'b1)       jd_cyc.push_back(cyc);
    if (change_base_id === 1'b1) cbi_cyc.push_back(cyc);
  end

  // Node controller model: after each launch, wait, then hold running for a while.
  bit cfg_rand = 0, cfg_stuck = 0;
  int cfg_delay = 0, cfg_len = 40;
  int nd_wait = 0, nd_on = 0;
  bit nd_stuck = 0;
  always @(negedge clk) begin
    if (reset) begin
      nd_wait = 0; nd_on = 0;
    end else if (run_write) begin
      nd_wait  = cfg_rand ? $urandom_range(0, T + 2) : cfg_delay;
      nd_on    = cfg_rand ? $urandom_range(1, 12) : cfg_len;
      nd_stuck = cfg_stuck || (cfg_rand && $urandom_range(0, 9) == 0);
    end
    if (nd_wait > 0) begin
      nd_wait--; node_running = '0;
    end else if (nd_on > 0) begin
      nd_on--; node_running = '1;
      if (nd_stuck) node_running[$urandom_range(0, NN - 1)] = 1'b0;
    end else begin
      node_running = '0;
    end
  end

  task automatic drive(input logic v, input logic [23:0] t, input logic r, input logic ab, input logic ec);
    cmd_valid = v; cmd_times = t; cmd_rotate = r; abort = ab; err_clear = ec;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(0, 24'd0, 0, 0, 0);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  int b_rw, b_jd, b_cbi, acc_cyc;

  initial begin
    @(negedge clk);
    do_reset();
    chk("rst_run_write", run_write, 0);
    chk("rst_run_times", run_times, 0);
    chk("rst_done_count", done_count, 0);
    chk("rst_cmd_ready", cmd_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_errs", {err_zero, err_start}, 0);

    // Single job, no rotate.
    cfg_delay = 0; cfg_len = 40;
    b_rw = rw_cyc.size(); b_jd = jd_cyc.size(); b_cbi = cbi_cyc.size();
    acc_cyc = cyc;
    drive(1, 24'd5, 0, 0, 0);
    idle(50);
    chk("t1_launches", rw_cyc.size() - b_rw, 1);
    if (rw_cyc.size() > b_rw) begin
      chk("t1_launch_latency", rw_cyc[b_rw] - acc_cyc, 2);
      chk("t1_run_times", rw_val[b_rw], 5);
    end
    chk("t1_job_done", jd_cyc.size() - b_jd, 1);
    chk("t1_done_count", done_count, 1);
    chk("t1_no_rotate", cbi_cyc.size() - b_cbi, 0);
    chk("t1_busy", busy, 0);

    // Long job keeps FSM busy, then fill the FIFO with four commands.
    do_reset();
    b_rw = rw_cyc.size(); b_jd = jd_cyc.size(); b_cbi = cbi_cyc.size();
    cfg_len = 30;
    drive(1, 24'd9, 0, 0, 0);
    idle(4);
    cfg_len = 3;
    drive(1, 24'd1, 0, 0, 0);
    drive(1, 24'd2, 1, 0, 0);
    drive(1, 24'd3, 0, 0, 0);
    drive(1, 24'd4, 1, 0, 0);
    chk("t2_full_ready", cmd_ready, 0);
    drive(1, 24'd99, 0, 0, 0);
    chk("t2_still_full", cmd_ready, 0);
    idle(120);
    chk("t2_launches", rw_cyc.size() - b_rw, 5);
    chk("t2_jobs_done", jd_cyc.size() - b_jd, 5);
    chk("t2_rotates", cbi_cyc.size() - b_cbi, 2);
    chk("t2_done_count", done_count, 5);
    if (rw_cyc.size() - b_rw == 5 && jd_cyc.size() - b_jd == 5 && cbi_cyc.size() - b_cbi == 2) begin
      for (int i = 0; i < 5; i++) chk("t2_order", rw_val[b_rw + i], (i == 0) ? 9 : i);
      chk("t2_rot_after_job2", cbi_cyc[b_cbi], jd_cyc[b_jd + 2] + 1);
      chk("t2_rot_after_job4", cbi_cyc[b_cbi + 1], jd_cyc[b_jd + 4] + 1);
      chk("t2_gap_norot", rw_cyc[b_rw + 1] - jd_cyc[b_jd], 2);
      chk("t2_gap_rot", rw_cyc[b_rw + 3] - jd_cyc[b_jd + 2], 4);
    end

    // Zero-count commands and sticky err_zero.
    do_reset();
    b_rw = rw_cyc.size();
    drive(1, 24'd0, 0, 0, 0);
    chk("t3_err_zero_set", err_zero, 1);
    idle(4);
    chk("t3_no_launch", rw_cyc.size() - b_rw, 0);
    chk("t3_busy", busy, 0);
    drive(1, 24'd0, 1, 0, 1);
    chk("t3_set_wins", err_zero, 1);
    drive(0, 24'd0, 0, 0, 1);
    chk("t3_cleared", err_zero, 0);

    // A stuck node bit forces the start timeout; the next job still runs.
    do_reset();
    b_rw = rw_cyc.size(); b_jd = jd_cyc.size();
    cfg_stuck = 1; cfg_len = 20;
    drive(1, 24'd7, 0, 0, 0);
    drive(1, 24'd6, 0, 0, 0);
    idle(4);
    cfg_stuck = 0;
    idle(40);
    chk("t4_err_start", err_start, 1);
    chk("t4_launches", rw_cyc.size() - b_rw, 2);
    chk("t4_jobs_done", jd_cyc.size() - b_jd, 1);
    chk("t4_done_count", done_count, 1);
    if (rw_cyc.size() - b_rw == 2) begin
      chk("t4_timeout_gap", rw_cyc[b_rw + 1] - rw_cyc[b_rw], T + 2);
      chk("t4_second_times", rw_val[b_rw + 1], 6);
    end

    // Abort during job 1's WAIT_DONE drops the queued jobs.
    do_reset();
    b_rw = rw_cyc.size(); b_jd = jd_cyc.size();
    cfg_len = 20;
    drive(1, 24'd5, 0, 0, 0);
    drive(1, 24'd6, 0, 0, 0);
    drive(1, 24'd7, 1, 0, 0);
    idle(6);
    drive(0, 24'd0, 0, 1, 0);
    idle(40);
    chk("t5_launches", rw_cyc.size() - b_rw, 1);
    chk("t5_jobs_done", jd_cyc.size() - b_jd, 1);
    chk("t5_done_count", done_count, 1);
    chk("t5_busy", busy, 0);

    // Reset during WAIT_DONE with two jobs queued.
    do_reset();
    drive(1, 24'd5, 0, 0, 0);
    drive(1, 24'd6, 0, 0, 0);
    drive(1, 24'd7, 0, 0, 0);
    idle(6);
    reset = 1'b1;
    idle(1);
    chk("t6_rst_run_write", run_write, 0);
    chk("t6_rst_busy", busy, 0);
    chk("t6_rst_ready", cmd_ready, 1);
    chk("t6_rst_done_count", done_count, 0);
    reset = 1'b0;
    b_rw = rw_cyc.size();
    idle(30);
    chk("t6_no_launch", rw_cyc.size() - b_rw, 0);

    // Randomized traffic, including timeouts, aborts, clears and resets.
    cfg_rand = 1;
    for (int i = 0; i < 2500; i++) begin
      reset = ($urandom_range(0, 599) == 0);
      drive($urandom_range(0, 2) != 0,
            ($urandom_range(0, 7) == 0) ? 24'd0 : 24'($urandom_range(1, 20)),
            $urandom_range(0, 1) == 1,
            $urandom_range(0, 39) == 0,
            $urandom_range(0, 19) == 0);
    end
    reset = 1'b0;
    idle(60);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
